// File: rtl/riscv_multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller.
// Holds opcode constants, the FSM state enum, the ALU-op class used
// between the FSM and the ALU decoder, the datapath mux encodings and a
// branch-condition helper.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
        ST_EXECR, ST_EXECI, ST_ALUWB, ST_BRANCH, ST_JAL, ST_JALR1, ST_JALR2,
        ST_LUI, ST_FAULT
    } state_e;

    // Class of ALU operation requested by the FSM; the decoder refines it.
    typedef enum logic [1:0] {
        ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_ITYPE
    } alu_op_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Branch resolution from A-B flags. bge also accepts zero so that
    // equal operands branch even if the sign flag is set.
    function automatic logic branch_taken(input logic [2:0] func3,
                                          input logic zero,
                                          input logic sign);
        case (func3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return sign;
            3'b101:  return !sign || zero;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/riscv_multicycle_controller_if.sv
// Shared memory port handshake between controller and memory.
//   mem_req   : access request (held until mem_ready)
//   mem_we    : write request
//   mem_ready : write accepted / read data valid this cycle
interface riscv_multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/riscv_multicycle_controller_alu_decoder.sv
// riscv_alu_decoder: combinational ALU control decoder.
//   alu_op      : operation class from the FSM
//   func3       : IR[14:12]
//   func7_5     : IR[30], selects sub for R-type
//   alu_control : ALU operation code
module riscv_alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_e    alu_op,
    input  logic [2:0] func3,
    input  logic       func7_5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (func3)
                    3'b000:  alu_control = func7_5 ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: begin
                case (func3)
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RV32I control FSM with bus watchdog and fault trapping.
//   clk, rst           : clock, synchronous active-high reset
//   op, func3, func7   : instruction register fields
//   zero, sign         : ALU flags (combinational)
//   mem                : memory handshake (mem_req, mem_we, mem_ready)
//   AdrSrc..ALUControl : datapath mux selects and write strobes
//   instr_retired      : pulse on the final cycle of each instruction
//   bus_error, illegal_instr : sticky faults, cleared only by rst
module riscv_multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       sign,
    riscv_multicycle_controller_if.master mem,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_retired,
    output logic       bus_error,
    output logic       illegal_instr
);
    // A zero-width counter is illegal, so keep at least one bit when disabled.
    localparam int CNT_W = (TMO_W < 1) ? 1 : TMO_W;
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             bus_error_q, bus_error_d;
    logic             illegal_q, illegal_d;

    logic       req, we, adr, irw, pcw, rw, ret, timeout_hit;
    logic [1:0] srca, srcb, res;
    logic [2:0] imm, alu_ctrl;
    alu_op_e    alu_op;
    logic       unused_func7;

    assign unused_func7 = ^{func7[6], func7[4:0]};

    riscv_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .func3       (func3),
        .func7_5     (func7[5]),
        .alu_control (alu_ctrl)
    );

    always_comb begin
        state_d     = state_q;
        bus_error_d = bus_error_q;
        illegal_d   = illegal_q;
        req = 1'b0; we = 1'b0; adr = 1'b0; irw = 1'b0;
        pcw = 1'b0; rw = 1'b0; ret = 1'b0;
        srca = SRCA_PC; srcb = SRCB_B; res = RES_ALUOUT; imm = IMM_I;
        alu_op = ALUOP_ADD;

        case (state_q)
            ST_FETCH: begin
                req  = 1'b1;
                srcb = SRCB_FOUR;
                res  = RES_ALURES;
                irw  = mem.mem_ready;
                pcw  = mem.mem_ready;
                if (mem.mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                // Precompute OldPC+imm into ALUOut for branch/jal targets.
                srca = SRCA_OLDPC;
                srcb = SRCB_IMM;
                case (op)
                    OP_LOAD:   state_d = ST_MEMADR;
                    OP_STORE:  begin imm = IMM_S; state_d = ST_MEMADR; end
                    OP_RTYPE:  state_d = ST_EXECR;
                    OP_ITYPE:  state_d = ST_EXECI;
                    OP_BRANCH: begin imm = IMM_B; state_d = ST_BRANCH; end
                    OP_JAL:    begin imm = IMM_J; state_d = ST_JAL; end
                    OP_JALR:   state_d = ST_JALR1;
                    OP_LUI:    begin imm = IMM_U; state_d = ST_LUI; end
                    default: begin
                        state_d   = ST_FAULT;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: begin
                srca = SRCA_A;
                srcb = SRCB_IMM;
                imm  = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                req = 1'b1;
                adr = 1'b1;
                if (mem.mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWB: begin
                res = RES_DATA;
                rw  = 1'b1;
                ret = 1'b1;
                state_d = ST_FETCH;
            end
            ST_MEMWRITE: begin
                req = 1'b1;
                we  = 1'b1;
                adr = 1'b1;
                if (mem.mem_ready) begin
                    ret     = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXECR: begin
                srca   = SRCA_A;
                alu_op = ALUOP_RTYPE;
                state_d = ST_ALUWB;
            end
            ST_EXECI: begin
                srca   = SRCA_A;
                srcb   = SRCB_IMM;
                alu_op = ALUOP_ITYPE;
                state_d = ST_ALUWB;
            end
            ST_ALUWB: begin
                rw  = 1'b1;
                ret = 1'b1;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                srca   = SRCA_A;
                alu_op = ALUOP_SUB;
                pcw    = branch_taken(func3, zero, sign);
                ret    = 1'b1;
                state_d = ST_FETCH;
            end
            ST_JAL: begin
                // PC <- ALUOut (target) while ALU forms the link OldPC+4.
                srca = SRCA_OLDPC;
                srcb = SRCB_FOUR;
                pcw  = 1'b1;
                state_d = ST_ALUWB;
            end
            ST_JALR1: begin
                srca = SRCA_A;
                srcb = SRCB_IMM;
                state_d = ST_JALR2;
            end
            ST_JALR2: begin
                srca = SRCA_OLDPC;
                srcb = SRCB_FOUR;
                pcw  = 1'b1;
                state_d = ST_ALUWB;
            end
            ST_LUI: begin
                res = RES_IMM;
                imm = IMM_U;
                rw  = 1'b1;
                ret = 1'b1;
                state_d = ST_FETCH;
            end
            default: ;  // ST_FAULT: everything idle until reset
        endcase

        // A late mem_ready on the final allowed cycle still completes.
        timeout_hit = WDOG_EN && req && !mem.mem_ready && (tmo_q == TMO_LAST);
        if (timeout_hit) begin
            state_d     = ST_FAULT;
            bus_error_d = 1'b1;
        end

        if (WDOG_EN && req && !mem.mem_ready && (state_d == state_q))
            tmo_d = tmo_q + CNT_W'(1);
        else
            tmo_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            tmo_q       <= '0;
            bus_error_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            bus_error_q <= bus_error_d;
            illegal_q   <= illegal_d;
        end
    end

    // Every output is forced low during reset so an aborted instruction
    // cannot write state in the reset cycle.
    assign mem.mem_req    = req & ~rst;
    assign mem.mem_we     = we & ~rst;
    assign AdrSrc         = adr & ~rst;
    assign IRWrite        = irw & ~rst;
    assign PCWrite        = pcw & ~rst;
    assign RegWrite       = rw & ~rst;
    assign instr_retired  = ret & ~rst;
    assign ALUSrcA        = rst ? 2'b00 : srca;
    assign ALUSrcB        = rst ? 2'b00 : srcb;
    assign ResultSrc      = rst ? 2'b00 : res;
    assign ImmSrc         = rst ? 3'b000 : imm;
    assign ALUControl     = rst ? 3'b000 : alu_ctrl;
    assign bus_error      = bus_error_q & ~rst;
    assign illegal_instr  = illegal_q & ~rst;

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
module tb_riscv_multicycle_controller;

    // Strobe vector: {mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite,
    //                 instr_retired, bus_error, illegal_instr}
    localparam logic [8:0] S_NONE   = 9'b000000000;
    localparam logic [8:0] S_FETCH  = 9'b100110000;
    localparam logic [8:0] S_FWAIT  = 9'b100000000;
    localparam logic [8:0] S_RDWAIT = 9'b101000000;
    localparam logic [8:0] S_WRWAIT = 9'b111000000;
    localparam logic [8:0] S_WR     = 9'b111000100;
    localparam logic [8:0] S_WB     = 9'b000001100;
    localparam logic [8:0] S_BR_TK  = 9'b000010100;
    localparam logic [8:0] S_BR_NT  = 9'b000000100;
    localparam logic [8:0] S_PCW    = 9'b000010000;
    localparam logic [8:0] S_ILL    = 9'b000000001;
    localparam logic [8:0] S_BUS    = 9'b000000010;

    // Mux vector: {ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl}
    localparam logic [11:0] K_ALL  = 12'b11_11_11_111_111;
    localparam logic [11:0] K_DEC  = 12'b11_11_00_111_111;
    localparam logic [11:0] K_ABC  = 12'b11_11_00_000_111;
    localparam logic [11:0] K_ABRC = 12'b11_11_11_000_111;
    localparam logic [11:0] K_R    = 12'b00_00_11_000_000;
    localparam logic [11:0] K_RI   = 12'b00_00_11_111_000;
    localparam logic [11:0] K_NONE = 12'b00_00_00_000_000;

    typedef struct {
        string       nm;
        logic [8:0]  strb;
        logic [11:0] mx;
        logic [11:0] mk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       zero, sign;
    logic       AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc, ALUControl;
    logic       instr_retired, bus_error, illegal_instr;

    riscv_multicycle_controller_if mem_bus ();

    riscv_multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .func3         (func3),
        .func7         (func7),
        .zero          (zero),
        .sign          (sign),
        .mem           (mem_bus.master),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ResultSrc     (ResultSrc),
        .ImmSrc        (ImmSrc),
        .ALUControl    (ALUControl),
        .instr_retired (instr_retired),
        .bus_error     (bus_error),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle the DUT presents a control word; compare it
    // against the oldest expectation queued by the stimulus process.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t       e;
            logic [8:0]  a_s;
            logic [11:0] a_m;
            e   = q.pop_front();
            a_s = {mem_bus.mem_req, mem_bus.mem_we, AdrSrc, IRWrite, PCWrite,
                   RegWrite, instr_retired, bus_error, illegal_instr};
            a_m = {ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
            checks++;
            if (a_s !== e.strb || (a_m & e.mk) !== (e.mx & e.mk)) begin
                failures++;
                $display("FAIL %s: strobes got %b want %b, muxes got %b want %b (mask %b)",
                         e.nm, a_s, e.strb, a_m, e.mx, e.mk);
            end
        end
    end

    task automatic cyc(input logic r, input logic rdy, input string nm,
                       input logic [8:0] strb, input logic [11:0] mx,
                       input logic [11:0] mk);
        rst = r;
        mem_bus.mem_ready = rdy;
        q.push_back('{nm, strb, mx, mk});
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7);
        op = o; func3 = f3; func7 = f7;
    endtask

    task automatic fetch_ok();
        cyc(0, 1, "fetch", S_FETCH, 12'b00_10_10_000_000, K_ALL);
    endtask

    task automatic decode(input logic [2:0] imm);
        cyc(0, 1, "decode", S_NONE, {2'b01, 2'b01, 2'b00, imm, 3'b000}, K_DEC);
    endtask

    initial begin
        rst = 1'b1; mem_bus.mem_ready = 1'b0;
        op = 7'h00; func3 = 3'b000; func7 = 7'h00; zero = 1'b0; sign = 1'b0;
        @(posedge clk);
        #1;
        cyc(1, 1, "reset_a", S_NONE, 12'h000, K_ALL);
        cyc(1, 0, "reset_b", S_NONE, 12'h000, K_ALL);

        // add x3,x1,x2 = 0x002081B3
        instr(7'b0110011, 3'b000, 7'h00);
        fetch_ok(); decode(3'b000);
        cyc(0, 1, "add_execr", S_NONE, 12'b10_00_00_000_000, K_ABC);
        cyc(0, 1, "add_aluwb", S_WB, 12'h000, K_R);

        // sub
        instr(7'b0110011, 3'b000, 7'h20);
        fetch_ok(); decode(3'b000);
        cyc(0, 1, "sub_execr", S_NONE, 12'b10_00_00_000_001, K_ABC);
        cyc(0, 1, "sub_aluwb", S_WB, 12'h000, K_R);

        // xori
        instr(7'b0010011, 3'b100, 7'h00);
        fetch_ok(); decode(3'b000);
        cyc(0, 1, "xori_execi", S_NONE, 12'b10_01_00_000_110, K_DEC);
        cyc(0, 1, "xori_aluwb", S_WB, 12'h000, K_R);

        // lw with three wait cycles; ready lands on the watchdog's last cycle
        instr(7'b0000011, 3'b010, 7'h00);
        fetch_ok(); decode(3'b000);
        cyc(0, 1, "lw_memadr", S_NONE, 12'b10_01_00_000_000, K_DEC);
        cyc(0, 0, "lw_wait1", S_RDWAIT, 12'h000, K_R);
        cyc(0, 0, "lw_wait2", S_RDWAIT, 12'h000, K_R);
        cyc(0, 0, "lw_wait3", S_RDWAIT, 12'h000, K_R);
        cyc(0, 1, "lw_ready_at_limit", S_RDWAIT, 12'h000, K_R);
        cyc(0, 1, "lw_memwb", S_WB, 12'b00_00_01_000_000, K_R);

        // sw with one wait cycle
        instr(7'b0100011, 3'b010, 7'h00);
        fetch_ok(); decode(3'b001);
        cyc(0, 1, "sw_memadr", S_NONE, 12'b10_01_00_001_000, K_DEC);
        cyc(0, 0, "sw_wait", S_WRWAIT, 12'h000, K_NONE);
        cyc(0, 1, "sw_write", S_WR, 12'h000, K_NONE);

        // branches
        instr(7'b1100011, 3'b101, 7'h00); zero = 1'b1; sign = 1'b1;
        fetch_ok(); decode(3'b010);
        cyc(0, 1, "bge_taken", S_BR_TK, 12'b10_00_00_000_001, K_ABRC);
        instr(7'b1100011, 3'b100, 7'h00); zero = 1'b0; sign = 1'b0;
        fetch_ok(); decode(3'b010);
        cyc(0, 1, "blt_not_taken", S_BR_NT, 12'b10_00_00_000_001, K_ABRC);
        instr(7'b1100011, 3'b000, 7'h00); zero = 1'b1;
        fetch_ok(); decode(3'b010);
        cyc(0, 1, "beq_taken", S_BR_TK, 12'b10_00_00_000_001, K_ABRC);
        instr(7'b1100011, 3'b001, 7'h00);
        fetch_ok(); decode(3'b010);
        cyc(0, 1, "bne_not_taken", S_BR_NT, 12'b10_00_00_000_001, K_ABRC);
        instr(7'b1100011, 3'b010, 7'h00);
        fetch_ok(); decode(3'b010);
        cyc(0, 1, "branch_bad_func3", S_BR_NT, 12'b10_00_00_000_001, K_ABRC);
        zero = 1'b0;

        // jal
        instr(7'b1101111, 3'b000, 7'h00);
        fetch_ok(); decode(3'b011);
        cyc(0, 1, "jal_pcw", S_PCW, 12'b01_10_00_000_000, K_ABRC);
        cyc(0, 1, "jal_aluwb", S_WB, 12'h000, K_R);

        // jalr
        instr(7'b1100111, 3'b000, 7'h00);
        fetch_ok(); decode(3'b000);
        cyc(0, 1, "jalr1", S_NONE, 12'b10_01_00_000_000, K_DEC);
        cyc(0, 1, "jalr2_pcw", S_PCW, 12'b01_10_00_000_000, K_ABRC);
        cyc(0, 1, "jalr_aluwb", S_WB, 12'h000, K_R);

        // lui
        instr(7'b0110111, 3'b000, 7'h00);
        fetch_ok(); decode(3'b100);
        cyc(0, 1, "lui_wb", S_WB, 12'b00_00_11_100_000, K_RI);

        // reset in the middle of a store
        instr(7'b0100011, 3'b010, 7'h00);
        fetch_ok(); decode(3'b001);
        cyc(0, 1, "sw2_memadr", S_NONE, 12'b10_01_00_001_000, K_DEC);
        cyc(0, 0, "sw2_wait", S_WRWAIT, 12'h000, K_NONE);
        cyc(1, 1, "rst_in_memwrite", S_NONE, 12'h000, K_ALL);
        cyc(0, 0, "fetch_after_rst", S_FWAIT, 12'b00_10_10_000_000, K_ALL);

        // illegal opcode
        instr(7'h7F, 3'b000, 7'h00);
        fetch_ok(); decode(3'b000);
        cyc(0, 1, "illegal_fault", S_ILL, 12'h000, K_ALL);
        cyc(0, 1, "illegal_sticky", S_ILL, 12'h000, K_ALL);
        cyc(1, 0, "illegal_reset", S_NONE, 12'h000, K_ALL);

        // bus timeout in fetch
        cyc(0, 0, "tmo_wait1", S_FWAIT, 12'h000, K_NONE);
        cyc(0, 0, "tmo_wait2", S_FWAIT, 12'h000, K_NONE);
        cyc(0, 0, "tmo_wait3", S_FWAIT, 12'h000, K_NONE);
        cyc(0, 0, "tmo_wait4", S_FWAIT, 12'h000, K_NONE);
        cyc(0, 0, "tmo_fault", S_BUS, 12'h000, K_ALL);
        cyc(0, 1, "tmo_fault_held", S_BUS, 12'h000, K_ALL);
        cyc(1, 1, "tmo_reset", S_NONE, 12'h000, K_ALL);

        // recovery
        instr(7'b0110111, 3'b000, 7'h00);
        fetch_ok(); decode(3'b100);
        cyc(0, 1, "lui_after_recovery", S_WB, 12'b00_00_11_100_000, K_RI);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_controller.md
# riscv_multicycle_controller

Multi-cycle control unit for the RV32I subset core: a Moore/Mealy FSM sequencing fetch, decode, execute, memory and writeback over a shared memory port with a valid/ready handshake. It replaces the single-cycle main/ALU decoder pair, adds wait-state-tolerant memory access, a bus timeout watchdog, illegal-opcode trapping and a retire strobe. Sits between the instruction register and the multi-cycle datapath (PC, OldPC, A/B, ALUOut, Data registers).

## Interface
- TIMEOUT_CYCLES, 64: max cycles `mem_req` may wait for `mem_ready`; 0 disables the watchdog.
- TMO_W, $clog2(TIMEOUT_CYCLES+1): timeout counter width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- op  in  7  IR[6:0]; func3  in  3  IR[14:12]; func7  in  7  IR[31:25].
- zero, sign  in  1  ALU result flags (registered values not required; combinational from ALU).
- mem_ready  in  1  memory accepted write / read data valid this cycle.
- mem_req  out  1  memory access request; mem_we  out  1  write request (MemWrite).
- AdrSrc  out  1  0=PC, 1=Result; IRWrite, PCWrite, RegWrite  out  1 each.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A; ALUSrcB  out  2  00 B, 01 ImmExt, 10 const 4.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 xor.
- instr_retired  out  1  one-cycle pulse on the last cycle of each instruction.
- bus_error, illegal_instr  out  1  sticky fault flags, cleared only by rst.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, FAULT.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, add; IRWrite=PCWrite=mem_ready; advance to DECODE only on mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut=OldPC+imm); ImmSrc from op. Next by op: 3/35→MEMADR, 51→EXECR, 19→EXECI, 99→BRANCH, 111→JAL, 103→JALR1, 55→LUI, other→FAULT (sets illegal_instr).
- MEMADR: A+imm (ImmSrc I for lw, S for sw) → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; wait for mem_ready → MEMWB. MEMWB: ResultSrc=01, RegWrite=1, retire → FETCH.
- MEMWRITE: mem_req=mem_we=1, AdrSrc=1; on mem_ready retire → FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl via decoder (add/sub by func7[5], and, or, slt) → ALUWB. EXECI: ALUSrcB=01, addi/xori/ori/slti → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, retire → FETCH.
- BRANCH: A−B (sub), ResultSrc=00; PCWrite = beq:zero, bne:!zero, blt:sign, bge:!sign|zero; unknown func3 → no write; retire → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1 → ALUWB (writes OldPC+4).
- JALR1: A+imm → ALUOut. JALR2: OldPC+4, ResultSrc=00, PCWrite=1 (datapath clears bit 0) → ALUWB.
- LUI: ResultSrc=11, ImmSrc=100, RegWrite=1, retire → FETCH.
- Watchdog: counter increments each cycle mem_req=1 and mem_ready=0, clears on mem_ready or state change; reaching TIMEOUT_CYCLES → FAULT, sets bus_error. mem_ready same cycle as limit wins (no fault).
- FAULT: all strobes and mem_req 0; held until rst.

## Timing
- While rst=1 and on the reset edge: state←FETCH, counter←0, flags←0; all outputs 0 during rst (mem_req gated). First fetch request in cycle after rst deasserts.
- Zero-wait latencies (cycles): lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui 3. Each mem_ready-low cycle in FETCH/MEMREAD/MEMWRITE adds 1.
- mem_req, mem_we, AdrSrc stable while waiting; deassert the cycle after mem_ready.
- rst mid-instruction aborts it: no PCWrite/RegWrite/IRWrite in the reset cycle.

## Structure
- Package riscv_ctrl_pkg: opcode constants, state enum, ALUControl codes, ALUSrcA/B, ResultSrc, ImmSrc encodings.
- Sub-module riscv_alu_decoder (combinational): ALU-op class + func3/func7 → ALUControl; FSM, watchdog and flags in top.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready tied 1 → states F,D,EXECR,ALUWB; RegWrite in cycle 4, ALUControl=000 in EXECR, one retire pulse.
- lw with mem_ready low 3 cycles in MEMREAD → 8 total cycles, mem_req/AdrSrc=1 stable throughout, RegWrite only in MEMWB.
- bge with zero=1,sign=1 → PCWrite=1; blt with sign=0 → PCWrite=0; 3 cycles each.
- jalr → PCWrite in JALR2 with ResultSrc=00, RegWrite in following ALUWB, 5 cycles.
- TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH → FAULT after 4 wait cycles, bus_error=1, mem_req=0 until rst; opcode 0x7F → illegal_instr=1.
- rst asserted during MEMWRITE → no further mem_we, FETCH with mem_req=1 in the cycle after rst deasserts.
